// File: rtl/toggle_event_rx_pkg.sv
// rtl/toggle_event_rx_pkg.sv - shared defaults for the toggle event link
package toggle_event_rx_pkg;

  // Shared with the T flip-flop transmitter wrapper so both ends stay matched
  localparam int EVT_SYNC_STAGES_DEF = 2;
  localparam int EVT_CNT_W_DEF       = 4;

  // Local defaults for the receiver
  localparam int EVT_TOT_W_DEF       = 16;
  // Arming counter width: must hold values up to the largest legal SYNC_STAGES (4)
  localparam int EVT_ARM_W           = 3;

endpackage

// File: rtl/sync_ff_chain.sv
// rtl/sync_ff_chain.sv - plain flop chain for bringing async inputs into the clk domain
module sync_ff_chain #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] stage_q;
  logic [STAGES-1:0][W-1:0] stage_d;

  // Shift the input one stage per clock; no logic between stages
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  // Chain register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - turns level changes on a toggle link back into queued event pulses
module toggle_event_rx
  import toggle_event_rx_pkg::*;
#(
  parameter int SYNC_STAGES = EVT_SYNC_STAGES_DEF,
  parameter int CNT_W       = EVT_CNT_W_DEF,
  parameter int TOT_W       = EVT_TOT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] pending,
  output logic [TOT_W-1:0] total,
  output logic             overflow,
  output logic             armed
);

  localparam logic [CNT_W-1:0]     PEND_MAX = '1;
  localparam logic [EVT_ARM_W-1:0] ARM_LAST = EVT_ARM_W'(SYNC_STAGES);

  logic             sync;
  logic             prev_q,      prev_d;
  logic             armed_q,     armed_d;
  logic [EVT_ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             evt_pulse_q, evt_pulse_d;
  logic [CNT_W-1:0] pending_q,   pending_d;
  logic [TOT_W-1:0] total_q,     total_d;
  logic             overflow_q,  overflow_d;

  logic             edge_det;
  logic             acc;
  logic             at_max;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES),
    .W      (1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tog_in),
    .q     (sync)
  );

  // Edge detect and accept handshake; prev follows sync even while unarmed
  always_comb begin
    edge_det  = armed_q & (sync ^ prev_q);
    acc       = evt_valid & evt_ready;
    at_max    = (pending_q == PEND_MAX);
    prev_d    = sync;
    evt_pulse_d = edge_det;
  end

  // Hold off edge detection until the synchroniser and prev have settled after reset
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    if (!armed_q) begin
      if (arm_cnt_q == ARM_LAST) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 1'b1;
      end
    end
  end

  // Pending queue depth, sticky overflow (set beats clear) and wrapping total
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (edge_det && !acc) begin
      if (!at_max) begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!edge_det && acc) begin
      pending_d = pending_q - 1'b1;
    end
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (edge_det && !acc && at_max) begin
      overflow_d = 1'b1;
    end
    total_d = total_q + TOT_W'(edge_det);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= 1'b0;
      armed_q     <= 1'b0;
      arm_cnt_q   <= '0;
      evt_pulse_q <= 1'b0;
      pending_q   <= '0;
      total_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      armed_q     <= armed_d;
      arm_cnt_q   <= arm_cnt_d;
      evt_pulse_q <= evt_pulse_d;
      pending_q   <= pending_d;
      total_q     <= total_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = (pending_q != '0);
  assign evt_pulse = evt_pulse_q;
  assign pending   = pending_q;
  assign total     = total_q;
  assign overflow  = overflow_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// tb/tb_toggle_event_rx.sv - directed self-checking bench for toggle_event_rx
module tb_toggle_event_rx;

  logic        clk;
  logic        reset;
  logic        tog_in;
  logic        evt_ready;
  logic        ovf_clr;
  logic        evt_valid;
  logic        evt_pulse;
  logic [3:0]  pending;
  logic [15:0] total;
  logic        overflow;
  logic        armed;

  int tests;
  int fails;
  int pulses;
  int exp_total;

  toggle_event_rx dut (
    .clk       (clk),
    .reset     (reset),
    .tog_in    (tog_in),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_pulse (evt_pulse),
    .pending   (pending),
    .total     (total),
    .overflow  (overflow),
    .armed     (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One toggle followed by enough cycles for it to reach the counters
  task automatic toggle_and_wait();
    tog_in = ~tog_in;
    ticks(4);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    exp_total = 0;
    reset     = 1'b1;
    tog_in    = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // 1: remote level 1 held through reset must not create an event
    ticks(3);
    check("rst_armed",   32'(armed),     32'd0);
    check("rst_pending", 32'(pending),   32'd0);
    check("rst_total",   32'(total),     32'd0);
    check("rst_valid",   32'(evt_valid), 32'd0);
    check("rst_pulse",   32'(evt_pulse), 32'd0);
    check("rst_ovf",     32'(overflow),  32'd0);
    reset = 1'b0;
    tick();
    check("arm_c1", 32'(armed), 32'd0);
    tick();
    check("arm_c2", 32'(armed), 32'd0);
    tick();
    check("arm_c3", 32'(armed), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (evt_pulse) pulses++;
    end
    check("t1_no_pulse", 32'(pulses),  32'd0);
    check("t1_pending",  32'(pending), 32'd0);
    check("t1_total",    32'(total),   32'd0);

    // 2: single 0->1 flip, three edges of latency
    reset  = 1'b1;
    tog_in = 1'b0;
    ticks(3);
    reset = 1'b0;
    ticks(4);
    check("t2_armed", 32'(armed), 32'd1);
    tog_in = 1'b1;
    tick();
    check("t2_pulse_e0", 32'(evt_pulse), 32'd0);
    tick();
    check("t2_pulse_e1", 32'(evt_pulse), 32'd0);
    tick();
    exp_total = 1;
    check("t2_pulse_e2", 32'(evt_pulse), 32'd1);
    check("t2_pending",  32'(pending),   32'd1);
    check("t2_valid",    32'(evt_valid), 32'd1);
    check("t2_total",    32'(total),     32'(exp_total));
    tick();
    check("t2_pulse_e3", 32'(evt_pulse), 32'd0);

    // 3: five toggles queued, then drained one per cycle
    evt_ready = 1'b1;
    tick();
    check("t3_drain0", 32'(pending), 32'd0);
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) toggle_and_wait();
    exp_total += 5;
    check("t3_pending5", 32'(pending), 32'd5);
    check("t3_total",    32'(total),   32'(exp_total));
    evt_ready = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      tick();
      check($sformatf("t3_drain_%0d", i), 32'(pending), 32'(i));
    end
    check("t3_valid_low", 32'(evt_valid), 32'd0);
    tick();
    check("t3_ready_idle", 32'(pending), 32'd0);
    evt_ready = 1'b0;

    // 4: saturation at 15 with sticky overflow, then clear
    for (int i = 0; i < 16; i++) toggle_and_wait();
    exp_total += 16;
    check("t4_pending_sat", 32'(pending),  32'd15);
    check("t4_overflow",    32'(overflow), 32'd1);
    check("t4_total",       32'(total),    32'(exp_total));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr",     32'(overflow), 32'd0);
    check("t4_pending_kept", 32'(pending), 32'd15);
    // overflowing edge coinciding with ovf_clr: set wins, pulse and total still count
    tog_in = ~tog_in;
    ticks(2);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    exp_total += 1;
    check("t4_set_wins",  32'(overflow),  32'd1);
    check("t4_drop_pulse", 32'(evt_pulse), 32'd1);
    check("t4_drop_total", 32'(total),     32'(exp_total));
    check("t4_drop_pend", 32'(pending),   32'd15);
    tick();

    // 5: edge and accept in the same cycle leave pending unchanged
    evt_ready = 1'b1;
    ticks(12);
    evt_ready = 1'b0;
    check("t5_pending3", 32'(pending), 32'd3);
    tog_in = ~tog_in;
    ticks(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    exp_total += 1;
    check("t5_pulse",    32'(evt_pulse), 32'd1);
    check("t5_pending",  32'(pending),   32'd3);
    check("t5_total",    32'(total),     32'(exp_total));
    check("t5_overflow", 32'(overflow),  32'd1);
    tick();
    check("t5_pending_after", 32'(pending), 32'd3);

    // 6: reset mid-stream discards everything, then re-arm and count again
    for (int i = 0; i < 3; i++) toggle_and_wait();
    check("t6_pending6", 32'(pending), 32'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_pending", 32'(pending),   32'd0);
    check("t6_total",   32'(total),     32'd0);
    check("t6_ovf",     32'(overflow),  32'd0);
    check("t6_armed",   32'(armed),     32'd0);
    check("t6_valid",   32'(evt_valid), 32'd0);
    ticks(3);
    check("t6_rearmed", 32'(armed),   32'd1);
    check("t6_no_spur", 32'(pending), 32'd0);
    toggle_and_wait();
    check("t6_pending1", 32'(pending), 32'd1);
    check("t6_total1",   32'(total),   32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
